// File: rtl/voq_in_ctrl.sv
// -----------------------------------------------------------------------------
// voq_in_ctrl
//
// Ingress stage in front of the shared-memory switch VOQs. Framed words arrive
// tagged with a destination port (nub) and a priority. At frame start the
// destination VOQ occupancy is checked. The frame is then forwarded through a
// 2-entry skid buffer, held back until the VOQ has room (DROP_MODE = 0), or
// discarded (DROP_MODE = 1). When the last word of a forwarded frame leaves,
// a one-hot completion pulse is raised on the bit of its destination.
//
// Parameters
//   PORT_NUB   : number of destination ports (>= 2)
//   DATA_WIDTH : payload width
//   PRIORITY   : number of priority levels (>= 2)
//   DROP_MODE  : 0 = stall a frame whose VOQ is full at SOP, 1 = drop it
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/ready   : input handshake (in_ready is combinational)
//   in_data          : payload word
//   in_nub, in_pri   : destination / priority, sampled on SOP words only
//   in_sop, in_eop   : frame delimiters (both high = 1-word frame)
//   voq_full         : per-destination VOQ full flags
//   out_valid/ready  : output handshake, out_* driven from registers
//   out_data         : {nub, data}
//   out_pri          : frame priority
//   out_sop, out_eop : frame delimiters
//   done_out         : one-hot pulse on the EOP output transfer
//   drop_cnt         : dropped-frame count, saturating at 16'hFFFF
//   err_pulse        : protocol-error flag, registered, high for one cycle
//                      after the offending word was accepted
// -----------------------------------------------------------------------------
module voq_in_ctrl #(
    parameter int  PORT_NUB   = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  PRIORITY   = 4,
    parameter int  DROP_MODE  = 0,
    localparam int WIDTH_SEL  = $clog2(PORT_NUB),
    localparam int WIDTH_PRI  = $clog2(PRIORITY)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [WIDTH_SEL-1:0]            in_nub,
    input  logic [WIDTH_PRI-1:0]            in_pri,
    input  logic                            in_sop,
    input  logic                            in_eop,
    input  logic [PORT_NUB-1:0]             voq_full,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH_SEL+DATA_WIDTH-1:0] out_data,
    output logic [WIDTH_PRI-1:0]            out_pri,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [PORT_NUB-1:0]             done_out,
    output logic [15:0]                     drop_cnt,
    output logic                            err_pulse
);

    // Only reachable for non-power-of-two PORT_NUB: nub codes at or above
    // this limit have no VOQ behind them.
    localparam logic [WIDTH_SEL:0] NUB_LIM       = (WIDTH_SEL+1)'(PORT_NUB);
    localparam bit                 STALL_ON_FULL = (DROP_MODE == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH_SEL-1:0]  nub;
        logic [WIDTH_PRI-1:0]  pri;
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t               state;
    logic [WIDTH_SEL-1:0] cur_nub;
    logic [WIDTH_PRI-1:0] cur_pri;

    // Skid buffer: head_p1 is the FIFO head and drives the outputs directly,
    // skid_p0 holds the second entry while the head is blocked.
    ent_t head_p1;
    ent_t skid_p0;
    logic vld_p1;
    logic vld_p0;

    logic nub_bad;
    logic sop_full;
    logic rdy_state;
    logic accept;
    logic fwd;
    logic push;
    logic pop;
    logic skid_load;
    ent_t in_ent;

    // -------------------------------------------------------------------------
    // Input side: readiness, acceptance and the entry to be pushed
    // -------------------------------------------------------------------------
    always_comb begin
        nub_bad   = ({1'b0, in_nub} >= NUB_LIM);
        sop_full  = !nub_bad && voq_full[in_nub];
        rdy_state = 1'b1;
        case (state)
            IDLE:    rdy_state = !(in_sop && sop_full && STALL_ON_FULL);
            PASS:    rdy_state = !voq_full[cur_nub];
            default: rdy_state = 1'b1;
        endcase
    end

    // A full buffer (skid occupied) blocks input even when the head pops in
    // the same cycle, so count never has to go 2 -> 2.
    assign in_ready = !rst && !vld_p0 && rdy_state;
    assign accept   = in_valid && in_ready;
    assign fwd      = (state == PASS) ||
                      ((state == IDLE) && in_sop && !nub_bad && !sop_full);
    assign push     = accept && fwd;
    assign pop      = vld_p1 && out_ready;

    // Body words carry the nub/pri latched at SOP; a stray sop inside a
    // frame is forwarded as a plain body word.
    always_comb begin
        in_ent.data = in_data;
        in_ent.eop  = in_eop;
        if (state == IDLE) begin
            in_ent.nub = in_nub;
            in_ent.pri = in_pri;
            in_ent.sop = 1'b1;
        end else begin
            in_ent.nub = cur_nub;
            in_ent.pri = cur_pri;
            in_ent.sop = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM with registered error flag and drop counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_nub   <= '0;
            cur_pri   <= '0;
            err_pulse <= 1'b0;
            drop_cnt  <= 16'd0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!in_sop) begin
                            err_pulse <= 1'b1;
                        end else if (nub_bad || sop_full) begin
                            // Only reached when the frame is to be dropped:
                            // an unknown nub, or a full VOQ in drop mode.
                            err_pulse <= nub_bad;
                            if (in_eop) begin
                                drop_cnt <= sat_inc16(drop_cnt);
                            end else begin
                                state <= DROP;
                            end
                        end else begin
                            cur_nub <= in_nub;
                            cur_pri <= in_pri;
                            if (!in_eop) begin
                                state <= PASS;
                            end
                        end
                    end
                    PASS: begin
                        if (in_sop) begin
                            err_pulse <= 1'b1;
                        end
                        if (in_eop) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            state    <= IDLE;
                            drop_cnt <= sat_inc16(drop_cnt);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Skid buffer -> output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p0  <= 1'b0;
            head_p1 <= '0;
        end else if (vld_p0) begin
            if (pop) begin
                head_p1 <= skid_p0;
                vld_p0  <= 1'b0;
            end
        end else if (vld_p1) begin
            if (push && pop) begin
                head_p1 <= in_ent;
            end else if (push) begin
                vld_p0 <= 1'b1;
            end else if (pop) begin
                vld_p1 <= 1'b0;
            end
        end else if (push) begin
            head_p1 <= in_ent;
            vld_p1  <= 1'b1;
        end
    end

    assign skid_load = push && vld_p1 && !vld_p0 && !pop;

    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_p0 <= in_ent;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = {head_p1.nub, head_p1.data};
    assign out_pri   = head_p1.pri;
    assign out_sop   = head_p1.sop;
    assign out_eop   = head_p1.eop;

    always_comb begin
        done_out = '0;
        if (!rst && pop && head_p1.eop) begin
            done_out = PORT_NUB'(1) << head_p1.nub;
        end
    end

endmodule
